// File: rtl/bdd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bdd_pkg
//  Brief    : Shared field positions, constants and walk-action encoding for
//             the binary-decision-diagram classifier.
//  Revision : 1.0  initial release
// ============================================================================
package bdd_pkg;

    // RAM1 word: {reserved, thresh[9:0]}
    localparam int THRESH_MSB  = 9;

    // RAM2 word: {leaf_hi, leaf_lo, hi[7:0], lo[7:0]}
    localparam int LEAF_HI_BIT = 17;
    localparam int LEAF_LO_BIT = 16;
    localparam int HI_MSB      = 15;
    localparam int HI_LSB      = 8;
    localparam int LO_MSB      = 7;
    localparam int LO_LSB      = 0;

    // Class reported when a walk exhausts its visit budget without a leaf
    localparam logic [7:0] CLASS_OVERRUN = 8'hFF;

    // What the walker does on the coming clock edge
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,   // loader busy: abort walk, keep class
        ACT_LEAF  = 2'd1,   // leaf reached: publish class, restart
        ACT_GUARD = 2'd2,   // visit budget spent: publish overrun, restart
        ACT_STEP  = 2'd3    // follow branch to the next node
    } walk_act_e;

endpackage : bdd_pkg
`default_nettype wire

// File: rtl/bdd_node_mem.sv
`default_nettype none
// ============================================================================
//  Module   : bdd_node_mem
//  Brief    : Node memory with synchronous write and asynchronous read.
//             Addresses narrower than the array are zero-extended.
//  Revision : 1.0  initial release
// ============================================================================
module bdd_node_mem #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; contents are valid once written
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[IDX_W'(waddr_i)] <= wdata_i;
        end
    end

    // Combinational read so a node can be evaluated in the cycle it is reached
    assign rdata_o = mem_q[IDX_W'(raddr_i)];

endmodule : bdd_node_mem
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
//  Module   : top
//  Brief    : BDD classifier accelerator. Walks the diagram from node 0, one
//             node per clock, and registers the class of the reached leaf.
//             Any loader write aborts the walk and holds the last class.
//  Revision : 1.0  initial release
// ============================================================================
module top
    import bdd_pkg::*;
#(
    parameter int RAM1_DATA_WIDTH = 34,
    parameter int RAM2_DATA_WIDTH = 18,
    parameter int ADDR_WIDTH      = 4,
    parameter int DEPTH           = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [9:0]                 in_attr,
    input  logic                       we1,
    input  logic                       we2,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
    input  logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
    output logic [7:0]                 out_class
);

    localparam int                STEP_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0]      node_q, node_d;
    logic [STEP_W-1:0]          step_q, step_d;
    logic [7:0]                 class_q, class_d;

    logic [RAM1_DATA_WIDTH-1:0] ram1_rdata;
    logic [RAM2_DATA_WIDTH-1:0] ram2_rdata;
    logic                       ram1_we;
    logic                       ram2_we;
    logic                       ge;
    logic                       leaf;
    logic [7:0]                 sel;
    walk_act_e                  act;

    // Reserved RAM1 bits are stored but never steer the walk
    logic                       unused_reserved;
    assign unused_reserved = ^ram1_rdata[RAM1_DATA_WIDTH-1:THRESH_MSB+1];

    // A write coinciding with reset assertion must not land in memory
    assign ram1_we = we1 & ~rst;
    assign ram2_we = we2 & ~rst;

    bdd_node_mem #(
        .WIDTH      (RAM1_DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram1 (
        .clk     (clk),
        .we_i    (ram1_we),
        .waddr_i (in_addr),
        .wdata_i (ram1_data_in),
        .raddr_i (node_q),
        .rdata_o (ram1_rdata)
    );

    bdd_node_mem #(
        .WIDTH      (RAM2_DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram2 (
        .clk     (clk),
        .we_i    (ram2_we),
        .waddr_i (in_addr),
        .wdata_i (ram2_data_in),
        .raddr_i (node_q),
        .rdata_o (ram2_rdata)
    );

    // Evaluate the current node, choose the walk action and form next state
    always_comb begin
        node_d  = node_q;
        step_d  = step_q;
        class_d = class_q;

        ge   = (in_attr >= ram1_rdata[THRESH_MSB:0]);
        sel  = ge ? ram2_rdata[HI_MSB:HI_LSB] : ram2_rdata[LO_MSB:LO_LSB];
        leaf = ge ? ram2_rdata[LEAF_HI_BIT]   : ram2_rdata[LEAF_LO_BIT];

        if (we1 | we2) begin
            act = ACT_HOLD;
        end else if (leaf) begin
            act = ACT_LEAF;
        end else if (step_q == STEP_LAST) begin
            act = ACT_GUARD;
        end else begin
            act = ACT_STEP;
        end

        case (act)
            ACT_HOLD: begin
                node_d = '0;
                step_d = '0;
            end
            ACT_LEAF: begin
                class_d = sel;
                node_d  = '0;
                step_d  = '0;
            end
            ACT_GUARD: begin
                class_d = CLASS_OVERRUN;
                node_d  = '0;
                step_d  = '0;
            end
            default: begin
                node_d = sel[ADDR_WIDTH-1:0];
                step_d = step_q + 1'b1;
            end
        endcase
    end

    // Walk state and published class; reset takes effect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_q  <= '0;
            step_q  <= '0;
            class_q <= '0;
        end else begin
            node_q  <= node_d;
            step_q  <= step_d;
            class_q <= class_d;
        end
    end

    assign out_class = class_q;

endmodule : top
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_top
//  Brief    : Scoreboard bench for the BDD classifier. Stimulus pushes the
//             expected class with the cycle it is due; a monitor compares
//             out_class on the falling edge of that cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_top;

    logic        clk;
    logic        rst;
    logic [9:0]  in_attr;
    logic        we1;
    logic        we2;
    logic [3:0]  in_addr;
    logic [33:0] ram1_data_in;
    logic [17:0] ram2_data_in;
    logic [7:0]  out_class;

    top #(
        .RAM1_DATA_WIDTH (34),
        .RAM2_DATA_WIDTH (18),
        .ADDR_WIDTH      (4),
        .DEPTH           (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_attr      (in_attr),
        .we1          (we1),
        .we2          (we2),
        .in_addr      (in_addr),
        .ram1_data_in (ram1_data_in),
        .ram2_data_in (ram2_data_in),
        .out_class    (out_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter: after edge n the counter reads n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         due_q  [$];
    logic [7:0] exp_q  [$];
    string      name_q [$];
    int         n_total = 0;
    int         n_pass  = 0;

    // Monitor: compare every entry that falls due in this cycle
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            n_total = n_total + 1;
            if (due_q[0] < cyc) begin
                $display("FAIL %s: check missed (due cycle %0d, now %0d)",
                         name_q[0], due_q[0], cyc);
            end else if (out_class !== exp_q[0]) begin
                $display("FAIL %s: out_class=%02h expected %02h (cycle %0d)",
                         name_q[0], out_class, exp_q[0], cyc);
            end else begin
                n_pass = n_pass + 1;
            end
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_at(input int off, input logic [7:0] v, input string n);
        due_q.push_back(cyc + off);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    // One-cycle loader write; enables are low again on return
    task automatic wr(input logic w1, input logic w2, input logic [3:0] a,
                      input logic [9:0] th, input logic [17:0] d2);
        we1          = w1;
        we2          = w2;
        in_addr      = a;
        ram1_data_in = {24'hA5C3F0, th};
        ram2_data_in = d2;
        tick();
        we1 = 1'b0;
        we2 = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        in_attr      = 10'd0;
        we1          = 1'b0;
        we2          = 1'b0;
        in_addr      = 4'd0;
        ram1_data_in = '0;
        ram2_data_in = '0;

        run(2);
        expect_at(0, 8'd0, "reset_state");
        tick();
        rst = 1'b0;

        // Single-node tree: thresh 245, both branches are leaves (hi=7, lo=3)
        in_attr = 10'd14;
        wr(1'b1, 1'b1, 4'd0, 10'd245, {1'b1, 1'b1, 8'd7, 8'd3});
        expect_at(1, 8'd3, "single_lo");
        tick();
        in_attr = 10'd300;
        expect_at(1, 8'd7, "single_hi");
        tick();
        in_attr = 10'd245;
        expect_at(1, 8'd7, "single_eq_boundary");
        tick();

        // Two-level tree: node0 hi->leaf 9, lo->node1; node1 thresh 175, hi=4 lo=5
        in_attr = 10'd14;
        wr(1'b0, 1'b1, 4'd0, 10'd0,   {1'b1, 1'b0, 8'd9, 8'd1});
        wr(1'b1, 1'b0, 4'd1, 10'd175, 18'd0);
        wr(1'b0, 1'b1, 4'd1, 10'd0,   {1'b1, 1'b1, 8'd4, 8'd5});
        wr(1'b1, 1'b0, 4'd0, 10'd245, 18'd0);
        expect_at(1, 8'd7, "two_lvl_first_edge_held");
        expect_at(2, 8'd5, "two_lvl_lo_lo");
        run(2);
        in_attr = 10'd200;
        expect_at(1, 8'd5, "two_lvl_mid_held");
        expect_at(2, 8'd4, "two_lvl_lo_hi");
        run(2);
        in_attr = 10'd250;
        expect_at(1, 8'd9, "two_lvl_hi_leaf");
        tick();
        in_attr = 10'd175;
        expect_at(2, 8'd4, "two_lvl_node1_eq_boundary");
        run(2);
        in_attr = 10'd14;
        expect_at(2, 8'd5, "two_lvl_back_to_5");
        run(2);

        // Write during walk: node register is at node1 after this tick
        tick();
        in_attr = 10'd200;
        we1          = 1'b1;
        in_addr      = 4'd0;
        ram1_data_in = {24'hA5C3F0, 10'd245};
        expect_at(1, 8'd5, "write_hold_1");
        expect_at(2, 8'd5, "write_hold_2");
        expect_at(3, 8'd5, "write_hold_3");
        run(3);
        we1 = 1'b0;
        expect_at(1, 8'd5, "after_write_edge1");
        expect_at(2, 8'd4, "after_write_edge2");
        run(2);

        // Asynchronous reset mid-walk (node register at node1)
        tick();
        #2;
        rst = 1'b1;
        expect_at(0, 8'd0, "async_reset_immediate");
        tick();
        rst = 1'b0;
        expect_at(1, 8'd0, "post_reset_edge1");
        expect_at(2, 8'd4, "post_reset_class");
        run(2);

        // Loop guard: node0 branches back to itself without a leaf
        wr(1'b0, 1'b1, 4'd0, 10'd0, 18'd0);
        expect_at(31, 8'd4,  "guard_not_yet");
        expect_at(32, 8'hFF, "guard_overrun");
        expect_at(64, 8'hFF, "guard_repeat");
        run(64);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 100 && due_q.size() > 0; i++) tick();
        if (due_q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", due_q.size());
            n_total = n_total + due_q.size();
        end
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_top
`default_nettype wire

// File: doc/top.md
Name: top

Overview:
- Binary-decision-diagram classifier accelerator.
- Two node memories are loaded through a simple write port:
  - RAM1 holds per-node compare thresholds.
  - RAM2 holds per-node branch/leaf links.
- When no write is active, the block walks the diagram continuously from root node 0, one node per clock, using the 10-bit input attribute, and drives the reached leaf's 8-bit class.
- Top level of the accelerator; sits behind a host loader.

Parameters:
- RAM1_DATA_WIDTH, 34: RAM1 word width. Layout {reserved[33:10], thresh[9:0]}; reserved bits are stored but unused by traversal.
- RAM2_DATA_WIDTH, 18: RAM2 word width. Layout {leaf_hi[17], leaf_lo[16], hi[15:8], lo[7:0]}.
- ADDR_WIDTH, 4: write address width and node-pointer width. Only ptr[ADDR_WIDTH-1:0] is used.
- DEPTH, 32: entries per memory, and the maximum number of node visits per walk.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- in_attr, input, 10: attribute compared against node thresholds.
- we1, input, 1: RAM1 write enable.
- we2, input, 1: RAM2 write enable.
- in_addr, input, ADDR_WIDTH: write address, zero-extended into DEPTH entries.
- ram1_data_in, input, RAM1_DATA_WIDTH: RAM1 write data.
- ram2_data_in, input, RAM2_DATA_WIDTH: RAM2 write data.
- out_class, output, 8: last classification result, registered.

Behaviour:
- Reset (async, immediate):
  - out_class=0, node=0, step=0.
  - Memory contents are not cleared (undefined until written).
- Writes:
  - On posedge, if we1, RAM1[in_addr]<=ram1_data_in.
  - On posedge, if we2, RAM2[in_addr]<=ram2_data_in.
  - Both may be high together; both write the same address.
- Reads: combinational (asynchronous) on both memories, addressed by the node register.
- Write priority:
  - Any cycle with we1|we2: walk is aborted, node<=0, step<=0, out_class held.
  - Walking resumes on the first clock with both enables low.
- Walk, each clock with we1=we2=0:
  - ge = (in_attr >= RAM1[node].thresh), unsigned 10-bit.
  - Selection: if ge, sel=hi and leaf=leaf_hi; else sel=lo and leaf=leaf_lo.
  - If leaf: out_class<=sel, node<=0, step<=0; the walk restarts with the current in_attr.
  - Else if step==DEPTH-1: out_class<=8'hFF (loop/overrun guard), node<=0, step<=0.
  - Else: node<=sel[ADDR_WIDTH-1:0], step<=step+1.
- Latency: a path visiting k nodes updates out_class on the k-th clock edge after enables drop. A repeat result of the same value is not distinguishable. No valid strobe.
- in_attr may change at any time. It is sampled per node visit, so a mid-walk change affects the remaining nodes of that walk. A fully settled result is guaranteed one full walk after in_attr is stable.
- Reset mid-walk or mid-write: the walk state is cleared as above. A write on the same edge as reset assertion is not performed.

Decomposition:
- Package bdd_pkg holds:
  - Field position constants: THRESH_MSB=9, LEAF_HI_BIT=17, LEAF_LO_BIT=16, HI_MSB/LSB=15/8, LO_MSB/LSB=7/0.
  - CLASS_OVERRUN=8'hFF.
- Sub-module bdd_node_mem (params WIDTH, DEPTH, ADDR_WIDTH; sync write, async read), instantiated twice (RAM1, RAM2).
- The walk FSM (node and step registers plus out_class) lives in top.

Test Plan:
- Reset: assert rst with arbitrary state -> out_class=0 immediately, before any clock edge.
- Single-node tree:
  - Setup: RAM1[0].thresh=245, RAM2[0]={1,1,8'd7,8'd3}.
  - in_attr=14 -> out_class=3 one clock after we low.
  - in_attr=300 -> 7.
  - in_attr=245 -> 7 (>= boundary).
- Two-level tree:
  - Setup: RAM2[0]={1,0,8'd9,8'd1}, RAM1[1].thresh=175, RAM2[1]={1,1,8'd4,8'd5}, RAM1[0].thresh=245.
  - in_attr=14 -> 5 on the 2nd edge.
  - in_attr=200 -> 4.
  - in_attr=250 -> 9 on the 1st edge.
- Loop guard: RAM2[0]={0,0,8'd0,8'd0} -> out_class=8'hFF on the 32nd edge; repeats every 32 cycles.
- Write during walk:
  - Setup: two-level tree, out_class=5; change in_attr to 200 and pulse we1 (rewriting identical data) mid-walk.
  - Required: out_class stays 5 while we1 is high.
  - Required: out_class becomes 4 two edges after we1 drops.
- Async reset mid-walk: assert rst between edges -> out_class=0 at once; after release the walk restarts at node 0 and produces the correct class.
